// File: rtl/qchunk.sv
// qchunk: splits each innermost dti queue into chunks of at most CHUNK items
// by adding a new innermost end-of-transaction level. One registered output
// stage that can load and drain in the same cycle, so it sustains one item
// per cycle.
module qchunk #(
    parameter int unsigned TDIN    = 16,
    parameter int unsigned DIN_LVL = 1,
    parameter int unsigned CHUNK   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      din_valid,
    output logic                      din_ready,
    input  logic [DIN_LVL+TDIN-1:0]   din_data,
    output logic                      dout_valid,
    input  logic                      dout_ready,
    output logic [DIN_LVL+TDIN:0]     dout_data
);

    localparam int unsigned W_CNT = (CHUNK > 1) ? $clog2(CHUNK) : 1;
    localparam logic [W_CNT-1:0] CNT_LAST = W_CNT'(CHUNK - 1);

    logic                 vld;
    logic [DIN_LVL:0]     eot_q;
    logic [TDIN-1:0]      data_q;
    logic [W_CNT-1:0]     cnt;

    logic                 acc_c;
    logic                 ins_c;
    logic [DIN_LVL-1:0]   din_eot_c;
    logic [TDIN-1:0]      din_dat_c;

    // Handshake and chunk-end decode for the item currently offered on din
    always_comb begin
        din_eot_c = din_data[TDIN +: DIN_LVL];
        din_dat_c = din_data[TDIN-1:0];
        din_ready = !vld || dout_ready;
        acc_c     = din_valid && din_ready;
        ins_c     = (cnt == CNT_LAST) || din_eot_c[0];
    end

    // Output valid and chunk counter; counter only moves on an accepted item
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld <= 1'b0;
            cnt <= '0;
        end else begin
            if (acc_c) begin
                vld <= 1'b1;
            end else if (dout_ready) begin
                vld <= 1'b0;
            end
            if (acc_c) begin
                cnt <= ins_c ? '0 : cnt + W_CNT'(1);
            end
        end
    end

    // Payload register: original eot levels shifted up, chunk end at bit 0
    always_ff @(posedge clk) begin
        if (acc_c) begin
            data_q <= din_dat_c;
            eot_q  <= {din_eot_c, ins_c};
        end
    end

    assign dout_valid = vld;
    assign dout_data  = {eot_q, data_q};

endmodule

// File: doc/qchunk.md
# qchunk

Splits each innermost queue on a `dti` stream into chunks of at most CHUNK items by inserting a new innermost end-of-transaction level. Output queue depth is DIN_LVL+1. Sits directly upstream of `qlen_cnt` so that `qlen_cnt` (CNT_LVL=1) counts chunks per queue. Single registered output stage sustains one item per cycle.

## Interface
- TDIN, 16: data width in bits.
- DIN_LVL, 1: number of eot levels on `din`; must be ≥1.
- CHUNK, 4: maximum items per chunk; must be ≥1.
- W_CNT (local), max(1, $clog2(CHUNK)): chunk counter width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-low (0 = reset), sampled on the rising edge of clk.
- din  dti.consumer  DIN_LVL+TDIN  packed {eot[DIN_LVL-1:0], data[TDIN-1:0]}.
- dout  dti.producer  DIN_LVL+1+TDIN  packed {eot[DIN_LVL:0], data[TDIN-1:0]}.

## Operation
- State:
  - `cnt`: W_CNT bits, items already emitted in the current chunk.
  - Output register `{vld, eot_q, data_q}`.
- Accept: `acc = din.valid && din.ready`.
- Chunk-end flag: `ins = (cnt == CHUNK-1) || din.eot[0]`, evaluated on the accepted item.
- On `acc`:
  - `data_q <= din.data`.
  - `eot_q <= {din.eot, ins}`: original levels shifted up by one, new bit at position 0.
  - `cnt <= ins ? 0 : cnt+1`.
- A din.eot[0] item always closes the current chunk, so a set higher eot bit always implies eot_q[0]=1.
- Counter compare is exact. `cnt` never exceeds CHUNK-1, so no wrap logic is needed.
- CHUNK=1: `ins` is always 1; every item has eot[0]=1.
- Data is passed through unmodified. No items are dropped, merged or reordered.
- Reset (rst=0): `vld<=0`, `cnt<=0`. eot_q and data_q are don't-care.
  - Reset mid-chunk discards the held item and the partial-chunk count.
  - The first item after reset starts a fresh chunk.

## Timing
- dout.valid = vld, registered. dout.data = {eot_q, data_q}.
- din.ready = !vld || dout.ready, combinational from dout.ready.
- Register update, each cycle:
  - `vld <= acc ? 1 : (dout.ready ? 0 : vld)`.
  - Load and drain in the same cycle gives back-to-back items.
- Latency: one cycle from din acceptance to dout.valid.
- Throughput: one item per cycle while dout.ready is held high.
- dout.data is stable while dout.valid=1 and dout.ready=0. vld never drops without a handshake, except on reset.
- `cnt` changes only on `acc`. Backpressure does not affect chunk boundaries.
- Reset values: dout.valid=0. din.ready=1 from the cycle after reset is released; din.ready is also 1 during reset, since vld=0.

## Test plan
- **Partial last chunk.** CHUNK=4, DIN_LVL=1, dout.ready=1. Send one queue of data 0..9, din.eot=1 on item 9.
  - Required: outputs 0..9 on consecutive cycles, one cycle after input.
  - eot=2'b01 on items 3 and 7, 2'b11 on item 9, 2'b00 elsewhere.
- **Exact multiple.** CHUNK=4. Send an 8-item queue (eot on item 7), then a 3-item queue.
  - Required: first queue eot=01 at item 3, eot=11 at item 7.
  - Second queue eot=11 at its item 2, confirming `cnt` restarted at 0.
- **Backpressure.** CHUNK=4, 20-item queue, random dout.ready (50%) and random din.valid.
  - Required: output sequence and eot pattern identical to the ready=1 run.
  - dout.data never changes while valid && !ready.
  - din.ready=0 exactly when vld=1 and dout.ready=0.
- **Reset mid-chunk.** Accept items A, B; hold dout.ready=0; pulse rst=0 for one cycle. Then send a 4-item queue (eot on 4th) with dout.ready=1.
  - Required: dout.valid=0 the cycle after reset and B is never emitted.
  - eot: 00, 00, 00, 11 (first chunk after reset is a full 4-item chunk).
- **Degenerate cases.**
  - Single-item queue with CHUNK=4: required eot=2'b11.
  - CHUNK=1 with a 3-item queue: required eot=01, 01, 11.
- **Two-level input.** DIN_LVL=2, CHUNK=3. Inner queues of lengths 5 and 2 (din.eot=01 at item 4, 11 at item 6).
  - Required output eot: 000, 000, 001, 000, 011, 000, 111.
